// File: rtl/fifo_umbral.sv
// fifo_umbral: 8-deep FIFO with programmable almost-full/almost-empty thresholds and sticky error.
// Optional FIFO_WATERMARK_EN adds max_fill, the peak occupancy since the last reset/init.
module fifo_umbral #(
   parameter int DATA_WIDTH = 10,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  init,
   input  logic [ADDR_WIDTH-1:0] umbral_superior,
   input  logic [ADDR_WIDTH-1:0] umbral_inferior,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   fill_count
`ifdef FIFO_WATERMARK_EN
   ,output logic [ADDR_WIDTH:0]  max_fill
`endif
);
   localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  valid_q, valid_d, err_q, err_d, pop_eff, wr_en, clr;
   assign clr          = reset || init;
   assign full         = cnt_q == FULL_CNT;
   assign empty        = cnt_q == '0;
   assign almost_full  = (|umbral_superior) && (cnt_q >= {1'b0, umbral_superior});
   assign almost_empty = cnt_q <= {1'b0, umbral_inferior};
   assign fill_count   = cnt_q;
   assign data_out     = dout_q;
   assign valid_out    = valid_q;
   assign error        = err_q;
   always_comb begin
      pop_eff  = pop && !empty;
      wr_en    = push && (!full || pop_eff);
      wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop_eff ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_d    = (wr_en && !pop_eff) ? cnt_q + 1'b1 : (pop_eff && !wr_en) ? cnt_q - 1'b1 : cnt_q;
      dout_d   = pop_eff ? mem[rd_ptr_q] : dout_q;
      valid_d  = pop_eff;
      // a pop on empty is harmless when a push arrives in the same cycle
      err_d    = err_q || (push && !wr_en) || (pop && empty && !push);
   end
   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end
   always_ff @(posedge clk) if (wr_en) mem[wr_ptr_q] <= data_in;
`ifdef FIFO_WATERMARK_EN
   logic [ADDR_WIDTH:0] max_q, max_d;
   assign max_d    = (cnt_d > max_q) ? cnt_d : max_q;
   assign max_fill = max_q;
   always_ff @(posedge clk) max_q <= clr ? '0 : max_d;
`endif
endmodule

// File: tb/tb_fifo_umbral.sv
// tb_fifo_umbral: scoreboard bench for fifo_umbral; define FIFO_WATERMARK_EN to also check max_fill.
module tb_fifo_umbral;
   logic       clk = 0, reset = 0, init = 0, push = 0, pop = 0;
   logic [2:0] us = 0, ui = 0;
   logic [9:0] data_in = 0, data_out;
   logic       valid_out, full, empty, almost_full, almost_empty, error;
   logic [3:0] fill_count;
`ifdef FIFO_WATERMARK_EN
   logic [3:0] max_fill;
`endif
   int         errors = 0, checks = 0, mmax = 0;
   logic       merr = 0;
   logic [9:0] last_d = 0;
   logic [9:0] mq[$], sb[$];

   fifo_umbral dut (
      .clk(clk), .reset(reset), .init(init), .umbral_superior(us), .umbral_inferior(ui),
      .push(push), .data_in(data_in), .pop(pop), .data_out(data_out), .valid_out(valid_out),
      .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
      .error(error), .fill_count(fill_count)
`ifdef FIFO_WATERMARK_EN
      , .max_fill(max_fill)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic flags();
      check("empty", empty, mq.size() == 0);
      check("full", full, mq.size() == 8);
      check("count", fill_count, mq.size());
      check("almost_full", almost_full, us != 0 && mq.size() >= us);
      check("almost_empty", almost_empty, mq.size() <= ui);
      check("error", error, merr);
`ifdef FIFO_WATERMARK_EN
      check("max_fill", max_fill, mmax);
`endif
   endtask

   task automatic step(input logic p, input logic [9:0] d, input logic r);
      int  n;
      logic pe, we;
      n  = mq.size();
      pe = r && n != 0;
      we = p && (n < 8 || pe);
      if ((p && !we) || (r && n == 0 && !p)) merr = 1;
      if (pe) sb.push_back(mq.pop_front());
      if (we) mq.push_back(d);
      if (mq.size() > mmax) mmax = mq.size();
      push = p; data_in = d; pop = r;
      @(posedge clk); #1;
      push = 0; pop = 0;
      check("valid_out", valid_out, pe);
      if (valid_out) begin
         if (sb.size() == 0) check("spurious_valid", 1, 0);
         else begin
            last_d = sb.pop_front();
            check("data_out", data_out, last_d);
         end
      end else check("data_hold", data_out, last_d);
      flags();
   endtask

   task automatic clear(input logic use_reset, input logic p, input logic r);
      push = p; pop = r; data_in = 10'h155;
      if (use_reset) reset = 1; else init = 1;
      @(posedge clk); #1;
      reset = 0; init = 0; push = 0; pop = 0;
      mq.delete(); sb.delete(); merr = 0; mmax = 0; last_d = 0;
      check("clr_valid", valid_out, 0);
      check("clr_data", data_out, 0);
      flags();
   endtask

   initial begin
      clear(1, 0, 0);
      // basic ordering
      step(1, 10'h3A5, 0); step(1, 10'h1F0, 0); step(1, 10'h00F, 0);
      repeat (3) step(0, 0, 1);
      // thresholds
      us = 6; ui = 2;
      for (int i = 0; i < 6; i++) step(1, 10'(i * 37 + 5), 0);
      repeat (4) step(0, 0, 1);
      us = 0; ui = 7; #1;
      flags();
      us = 1; ui = 1; #1;
      flags();
      repeat (2) step(0, 0, 1);
      // full, overflow, push+pop at full
      us = 7; ui = 0;
      for (int i = 0; i < 8; i++) step(1, 10'(100 + i), 0);
      step(1, 10'h3FF, 0);
      step(1, 10'h2AA, 1);
      step(1, 10'h0AB, 1);
      // underflow then init
      clear(0, 0, 0);
      step(0, 0, 1);
      clear(0, 0, 0);
      // empty with push+pop: push accepted, no error
      step(1, 10'h111, 1);
      step(0, 0, 1);
      // wrap-around with interleaving
      us = 4; ui = 3;
      for (int i = 0; i < 12; i++) step(1, 10'($urandom_range(0, 1023)), i % 3 == 2);
      while (mq.size() != 0) step(0, 0, 1);
      // peak tracking and reset mid-stream
      clear(1, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 10'(200 + i), 0);
      repeat (5) step(0, 0, 1);
      step(1, 10'h055, 0); step(1, 10'h0AA, 0);
      clear(1, 1, 1);
      step(1, 10'h321, 0);
      step(0, 0, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
